// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding/hazard unit at decode: in-flight destination scoreboard, youngest-match forward selects, load-use stall.
// Optional saturating stall/forward counters are enabled by defining FWD_HAZARD_STATS_EN.
module fwd_hazard_scoreboard #(
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 1,
    parameter int ZERO_REG   = 31,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              flush,
    input  logic              dec_valid,
    input  logic [ADDR_W-1:0] dec_rn,
    input  logic [ADDR_W-1:0] dec_rm,
    input  logic              dec_use_rn,
    input  logic              dec_use_rm,
    input  logic [ADDR_W-1:0] dec_rd,
    input  logic              dec_wr,
    input  logic              dec_load,
    output logic [SEL_W-1:0]  fwd_sel_a,
    output logic [SEL_W-1:0]  fwd_sel_b,
    output logic              stall
`ifdef FWD_HAZARD_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       fwd_cnt
`endif
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    generate
        if (DEPTH < 1) begin : g_bad_depth
            $error("fwd_hazard_scoreboard: DEPTH must be at least 1");
        end
        if (LOAD_STAGE > DEPTH) begin : g_bad_load_stage
            $error("fwd_hazard_scoreboard: LOAD_STAGE must not exceed DEPTH");
        end
    endgenerate

    // Scoreboard state: entry 0 is the youngest (EX), entry DEPTH-1 the oldest.
    logic [DEPTH-1:0]  v_reg;
    logic [DEPTH-1:0]  v_next;
    logic [DEPTH-1:0]  ld_reg;
    logic [DEPTH-1:0]  ld_next;
    logic [ADDR_W-1:0] rd_reg  [DEPTH];
    logic [ADDR_W-1:0] rd_next [DEPTH];

    logic [DEPTH-1:0]  match_a;
    logic [DEPTH-1:0]  match_b;
    logic [DEPTH-1:0]  early_ld;

    logic [SEL_W-1:0]  sel_a_raw;
    logic [SEL_W-1:0]  sel_b_raw;
    logic              lu_a;
    logic              lu_b;
    logic              stall_int;
    logic              ins_bubble;

    logic              rn_live;
    logic              rm_live;

    assign rn_live = dec_valid && dec_use_rn && (dec_rn != ZERO_ADDR);
    assign rm_live = dec_valid && dec_use_rm && (dec_rm != ZERO_ADDR);

    // Per-entry comparators; early_ld marks loads whose data is not yet available.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        localparam bit IS_EARLY = (gi < LOAD_STAGE);
        assign match_a[gi]  = rn_live && v_reg[gi] && (rd_reg[gi] == dec_rn);
        assign match_b[gi]  = rm_live && v_reg[gi] && (rd_reg[gi] == dec_rm);
        assign early_ld[gi] = ld_reg[gi] && IS_EARLY;
    end

    // Scan oldest to youngest so the lowest matching index has the final word.
    always_comb begin
        sel_a_raw = '0;
        sel_b_raw = '0;
        lu_a      = 1'b0;
        lu_b      = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match_a[k]) begin
                sel_a_raw = SEL_W'(k + 1);
                lu_a      = early_ld[k];
            end
            if (match_b[k]) begin
                sel_b_raw = SEL_W'(k + 1);
                lu_b      = early_ld[k];
            end
        end
    end

    assign stall_int  = !reset && (lu_a || lu_b);
    assign stall      = stall_int;
    assign fwd_sel_a  = (reset || stall_int) ? '0 : sel_a_raw;
    assign fwd_sel_b  = (reset || stall_int) ? '0 : sel_b_raw;

    // A stalled or flushed decode slot enters the pipe as a bubble.
    assign ins_bubble = stall_int || flush || !dec_valid;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_next
        if (gi == 0) begin : g_head
            assign v_next[gi]  = !ins_bubble && dec_wr && (dec_rd != ZERO_ADDR);
            assign rd_next[gi] = dec_rd;
            assign ld_next[gi] = dec_load;
        end else begin : g_shift
            assign v_next[gi]  = v_reg[gi-1];
            assign rd_next[gi] = rd_reg[gi-1];
            assign ld_next[gi] = ld_reg[gi-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_reg  <= '0;
            ld_reg <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                rd_reg[k] <= '0;
            end
        end else if (!hold) begin
            v_reg  <= v_next;
            ld_reg <= ld_next;
            for (int k = 0; k < DEPTH; k++) begin
                rd_reg[k] <= rd_next[k];
            end
        end
    end

`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] fwd_cnt_reg;
    logic        fwd_any;

    assign fwd_any = (fwd_sel_a != '0) || (fwd_sel_b != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_reg <= '0;
            fwd_cnt_reg   <= '0;
        end else if (!hold) begin
            if (stall_int && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
            if (fwd_any && (fwd_cnt_reg != 32'hFFFF_FFFF)) begin
                fwd_cnt_reg <= fwd_cnt_reg + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign fwd_cnt   = fwd_cnt_reg;
`endif

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Scoreboard bench for fwd_hazard_scoreboard: directed vectors push expected outputs, a negedge monitor checks them.
module tb_fwd_hazard_scoreboard;

    localparam int ADDR_W = 5;
    localparam int SEL_W  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              hold;
    logic              flush;
    logic              dec_valid;
    logic [ADDR_W-1:0] dec_rn;
    logic [ADDR_W-1:0] dec_rm;
    logic              dec_use_rn;
    logic              dec_use_rm;
    logic [ADDR_W-1:0] dec_rd;
    logic              dec_wr;
    logic              dec_load;
    logic [SEL_W-1:0]  fwd_sel_a;
    logic [SEL_W-1:0]  fwd_sel_b;
    logic              stall;
`ifdef FWD_HAZARD_STATS_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       fwd_cnt;
`endif

    fwd_hazard_scoreboard dut (
        .clk        (clk),
        .reset      (reset),
        .hold       (hold),
        .flush      (flush),
        .dec_valid  (dec_valid),
        .dec_rn     (dec_rn),
        .dec_rm     (dec_rm),
        .dec_use_rn (dec_use_rn),
        .dec_use_rm (dec_use_rm),
        .dec_rd     (dec_rd),
        .dec_wr     (dec_wr),
        .dec_load   (dec_load),
        .fwd_sel_a  (fwd_sel_a),
        .fwd_sel_b  (fwd_sel_b),
        .stall      (stall)
`ifdef FWD_HAZARD_STATS_EN
        ,
        .stall_cnt  (stall_cnt),
        .fwd_cnt    (fwd_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string nm;
        int    a;
        int    b;
        int    st;
        bit    cnt_chk;
        int    scnt;
        int    fcnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string nm, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    // Monitor: the DUT outputs are combinational, so each queued vector is checked mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.nm, ".sel_a"}, int'(fwd_sel_a), e.a);
                check({e.nm, ".sel_b"}, int'(fwd_sel_b), e.b);
                check({e.nm, ".stall"}, int'(stall), e.st);
`ifdef FWD_HAZARD_STATS_EN
                if (e.cnt_chk) begin
                    check({e.nm, ".stall_cnt"}, int'(stall_cnt), e.scnt);
                    check({e.nm, ".fwd_cnt"}, int'(fwd_cnt), e.fcnt);
                end
`endif
                $display("[TB] %-10s a=%0d b=%0d stall=%0d", e.nm, fwd_sel_a, fwd_sel_b, stall);
            end
        end
    end

    task automatic step(input string nm, input bit rst, input bit hld, input bit fl, input bit vld,
                        input int rn, input bit urn, input int rm, input bit urm,
                        input int rd, input bit wr, input bit ld,
                        input int ea, input int eb, input int est,
                        input bit cc = 1'b0, input int sc = 0, input int fc = 0);
        exp_t e;
        @(posedge clk);
        #1;
        reset      = rst;
        hold       = hld;
        flush      = fl;
        dec_valid  = vld;
        dec_rn     = ADDR_W'(rn);
        dec_use_rn = urn;
        dec_rm     = ADDR_W'(rm);
        dec_use_rm = urm;
        dec_rd     = ADDR_W'(rd);
        dec_wr     = wr;
        dec_load   = ld;
        e.nm = nm; e.a = ea; e.b = eb; e.st = est;
        e.cnt_chk = cc; e.scnt = sc; e.fcnt = fc;
        exp_q.push_back(e);
    endtask

    initial begin
        reset = 1'b1; hold = 1'b0; flush = 1'b0; dec_valid = 1'b0;
        dec_rn = '0; dec_rm = '0; dec_use_rn = 1'b0; dec_use_rm = 1'b0;
        dec_rd = '0; dec_wr = 1'b0; dec_load = 1'b0;

        //   name          rst hld fl vld rn urn rm urm rd wr ld   a  b  st
        step("rst0",        1, 0, 0, 1,  1, 1,  1, 1,  1, 1, 1,   0, 0, 0);
        step("rst1",        1, 0, 0, 1,  1, 1,  1, 1,  1, 1, 1,   0, 0, 0);
        step("addi_x1",     0, 0, 0, 1,  0, 0,  0, 0,  1, 1, 0,   0, 0, 0);
        step("add_rn_x1",   0, 0, 0, 1,  1, 1,  3, 1,  2, 1, 0,   1, 0, 0);
        step("nop0",        0, 0, 0, 0,  0, 0,  0, 0,  0, 0, 0,   0, 0, 0);
        step("addi_x1b",    0, 0, 0, 1,  0, 0,  0, 0,  1, 1, 0,   0, 0, 0);
        step("nop1",        0, 0, 0, 0,  0, 0,  0, 0,  0, 0, 0,   0, 0, 0);
        step("add_rm_e1",   0, 0, 0, 1,  3, 1,  1, 1,  2, 1, 0,   0, 2, 0);
        step("add_rm_e2",   0, 0, 0, 1,  3, 1,  1, 1,  7, 1, 0,   0, 3, 0);
        step("addi_x1c",    0, 0, 0, 1,  0, 0,  0, 0,  1, 1, 0,   0, 0, 0);
        step("addi_x1x1",   0, 0, 0, 1,  1, 1,  0, 0,  1, 1, 0,   1, 0, 0);
        step("youngest",    0, 0, 0, 1,  7, 1,  1, 1,  8, 1, 0,   3, 1, 0);
        step("wr_x12",      0, 0, 0, 1,  0, 0,  0, 0, 12, 1, 0,   0, 0, 0);
        step("nop2",        0, 0, 0, 0,  0, 0,  0, 0,  0, 0, 0,   0, 0, 0);
        step("nop3",        0, 0, 0, 0,  0, 0,  0, 0,  0, 0, 0,   0, 0, 0);
        step("rd_x12_e2",   0, 0, 0, 1, 12, 1,  0, 0,  0, 0, 0,   3, 0, 0);
        step("rd_x12_gone", 0, 0, 0, 1, 12, 1,  0, 0,  0, 0, 0,   0, 0, 0);
        step("rst2",        1, 0, 0, 0,  0, 0,  0, 0,  0, 0, 0,   0, 0, 0);
        step("ldur_x4",     0, 0, 0, 1,  0, 0,  0, 0,  4, 1, 1,   0, 0, 0);
        step("lu_stall",    0, 0, 0, 1,  4, 1,  4, 1,  5, 1, 0,   0, 0, 1);
        step("lu_fwd",      0, 0, 0, 1,  4, 1,  4, 1,  5, 1, 0,   2, 2, 0);
        step("wr_x31",      0, 0, 0, 1,  0, 0,  0, 0, 31, 1, 0,   0, 0, 0, 1'b1, 1, 1);
        step("rd_x31",      0, 0, 0, 1, 31, 1, 31, 1,  0, 0, 0,   0, 0, 0);
        step("ldur_x4b",    0, 0, 0, 1,  0, 0,  0, 0,  4, 1, 1,   0, 0, 0);
        step("hold0",       0, 1, 0, 1,  4, 1,  0, 0,  0, 0, 0,   0, 0, 1);
        step("hold1",       0, 1, 0, 1,  4, 1,  0, 0,  0, 0, 0,   0, 0, 1);
        step("hold2",       0, 1, 0, 1,  4, 1,  0, 0,  0, 0, 0,   0, 0, 1);
        step("post_hold",   0, 0, 0, 1,  4, 1,  0, 0,  0, 0, 0,   0, 0, 1);
        step("post_bubble", 0, 0, 0, 1,  4, 1,  0, 0,  0, 0, 0,   2, 0, 0);
        step("flush_x6",    0, 0, 1, 1,  0, 0,  0, 0,  6, 1, 0,   0, 0, 0);
        step("rd_x6",       0, 0, 0, 1,  6, 1,  6, 1,  0, 0, 0,   0, 0, 0);
        step("ldur_x10",    0, 0, 0, 1,  0, 0,  0, 0, 10, 1, 1,   0, 0, 0);
        step("fl_stall",    0, 0, 1, 1, 10, 1,  0, 0,  0, 0, 0,   0, 0, 1);
        step("fl_after",    0, 0, 0, 1,  0, 0, 10, 1,  0, 0, 0,   0, 2, 0);
        step("ldur_x9",     0, 0, 0, 1,  0, 0,  0, 0,  9, 1, 1,   0, 0, 0);
        step("x9_stall",    0, 0, 0, 1,  9, 1,  0, 0,  0, 0, 0,   0, 0, 1);
        step("x9_reset",    1, 0, 0, 1,  9, 1,  0, 0,  0, 0, 0,   0, 0, 0);
        step("x9_postrst",  0, 0, 0, 1,  9, 1,  0, 0,  0, 0, 0,   0, 0, 0);
        step("ldur_x9b",    0, 0, 0, 1,  0, 0,  0, 0,  9, 1, 1,   0, 0, 0);
        step("x9_invalid",  0, 0, 0, 0,  9, 1,  9, 1,  0, 0, 0,   0, 0, 0);
        step("x9_fwd",      0, 0, 0, 1,  9, 1,  0, 0,  0, 0, 0,   2, 0, 0);

        // Let the monitor drain; an undrained queue counts as a failure.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
